sd_modulator: RTL and testbench

Second-order single-bit sigma-delta modulator. It converts signed PCM samples into a 1-bit oversampled bitstream.
- It is the transmit-side counterpart of the sd_filter decimation chain.
- Samples arrive on a valid/ready stream and are held for OSR bit periods.
- Bits are produced on each `ce` tick and drive a DAC pin or a loopback into sd_filter.

---
 rtl/sd_filter_pkg.sv | 51 +++++
 rtl/sd_mod_integrator.sv | 57 +++++
 rtl/sd_modulator.sv | 182 ++++++++++++++++++
 tb/tb_sd_modulator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_filter_pkg.sv
// -----------------------------------------------------------------------------
// sd_filter_pkg
// Shared definitions for the sigma-delta transmit and receive paths:
//   - sd_filter_cfg_t    : configuration record of the sd_filter decimator
//   - sd_modulator_cfg_t : configuration record of the sd_modulator
//   - sd_clamp()         : symmetric clamp of a signed value to +/-mag
//   - sd_sat()           : symmetric saturation to a signed width
//   - sd_full_scale()    : full-scale magnitude of a Q1.(w-1) sample
// -----------------------------------------------------------------------------
package sd_filter_pkg;

  // Decimation filter configuration (receive side).
  typedef struct packed {
    int in_w;    // output sample width
    int decim;   // decimation ratio
    int stages;  // CIC order
  } sd_filter_cfg_t;

  // Modulator configuration (transmit side).
  typedef struct packed {
    int in_w;    // input sample width, signed Q1.(in_w-1)
    int osr;     // bit ticks per input sample
    int acc_w;   // integrator width, same LSB weight as the input
    int lim;     // input clamp magnitude
  } sd_modulator_cfg_t;

  // Clamp a signed value into [-mag, +mag].
  function automatic logic signed [63:0] sd_clamp(input logic signed [63:0] value,
                                                  input logic signed [63:0] mag);
    if (value > mag) begin
      return mag;
    end else if (value < -mag) begin
      return -mag;
    end
    return value;
  endfunction

  // Saturate to the symmetric range of a signed word of the given width:
  // +/-(2**(width-1) - 1). The most negative code is never produced, so the
  // two rails have equal magnitude.
  function automatic logic signed [63:0] sd_sat(input logic signed [63:0] value,
                                                input int width);
    return sd_clamp(value, (64'sd1 <<< (width - 1)) - 64'sd1);
  endfunction

  // Magnitude of +FS for a Q1.(in_w-1) sample.
  function automatic logic signed [63:0] sd_full_scale(input int in_w);
    return 64'sd1 <<< (in_w - 1);
  endfunction

endpackage

// File: rtl/sd_mod_integrator.sv
// -----------------------------------------------------------------------------
// sd_mod_integrator
// Saturating accumulator used for both loop integrators of sd_modulator.
// The saturated next value is exported combinationally so the second stage
// and the quantiser can use it within the same tick.
//
// Ports:
//   clk         in   clock
//   aresetn     in   asynchronous active-low reset (accumulator -> 0)
//   clear_i     in   synchronous clear, priority over en_i
//   en_i        in   accumulate enable (bit-rate tick)
//   delta_i     in   signed increment, ACC_W+2 bits
//   acc_next_o  out  sat(acc + delta_i), the value stored when en_i=1
// -----------------------------------------------------------------------------
module sd_mod_integrator
  import sd_filter_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    clear_i,
  input  logic                    en_i,
  input  logic signed [ACC_W+1:0] delta_i,
  output logic signed [ACC_W-1:0] acc_next_o
);

  localparam int SUM_W = ACC_W + 2;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [SUM_W-1:0] sum;

  // NOTE: every variable of an always_comb gets a default before any branch,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    sum        = SUM_W'(acc_q) + delta_i;
    acc_next_o = ACC_W'(sd_sat(64'(sum), ACC_W));
    acc_d      = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_next_o;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement or process order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/sd_modulator.sv
// -----------------------------------------------------------------------------
// sd_modulator
// Second-order single-bit sigma-delta modulator. Signed PCM samples enter a
// one-entry buffer over a valid/ready handshake; each sample is held for OSR
// bit ticks and shaped by two saturating integrators with +/-FS feedback.
// STF = z^-1, NTF = (1 - z^-1)^2.
//
// Ports:
//   clk       in   clock
//   aresetn   in   asynchronous active-low reset
//   ce        in   bit-rate tick; loop, phase and sample load advance only here
//   clear     in   synchronous clear of all state (priority over ce, accept)
//   s_valid   in   input sample valid
//   s_ready   out  buffer empty (registered, no path from s_valid)
//   s_data    in   signed input sample, clamped to +/-LIM on accept
//   sd_out    out  modulator bit (1 -> +FS, 0 -> -FS)
//   sd_valid  out  one-cycle pulse after each ce tick
//   frame     out  high while phase == 0
//   underrun  out  sticky: a sample period began with an empty buffer
// -----------------------------------------------------------------------------
module sd_modulator
  import sd_filter_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OSR   = 64,
  parameter int ACC_W = IN_W + 4,
  parameter int LIM   = 3 * 2 ** (IN_W - 3)
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   ce,
  input  logic                   clear,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [IN_W-1:0] s_data,
  output logic                   sd_out,
  output logic                   sd_valid,
  output logic                   frame,
  output logic                   underrun
);

  localparam sd_modulator_cfg_t CFG = '{in_w: IN_W, osr: OSR, acc_w: ACC_W, lim: LIM};

  localparam int PH_W  = (CFG.osr > 2) ? $clog2(CFG.osr) : 1;
  localparam int SUM_W = CFG.acc_w + 2;

  localparam logic [PH_W-1:0]         PH_LAST = PH_W'(CFG.osr - 1);
  localparam logic signed [SUM_W-1:0] FS      = SUM_W'(sd_full_scale(CFG.in_w));

  // State
  logic [PH_W-1:0]         phase_q,    phase_d;
  logic signed [IN_W-1:0]  buf_q,      buf_d;
  logic                    buf_full_q, buf_full_d;
  logic signed [IN_W-1:0]  x_cur_q,    x_cur_d;
  logic                    sd_out_q,   sd_out_d;
  logic                    sd_valid_q, sd_valid_d;
  logic                    underrun_q, underrun_d;

  // Loop datapath
  logic signed [SUM_W-1:0] fb;
  logic signed [SUM_W-1:0] int1_delta;
  logic signed [SUM_W-1:0] int2_delta;
  logic signed [ACC_W-1:0] int1_next;
  logic signed [ACC_W-1:0] int2_next;

  // Handshake / sequencing
  logic                    accept;
  logic                    period_end;
  logic signed [IN_W-1:0]  s_data_clamped;

  // ---------------------------------------------------------------------------
  // Loop filter: int1_n = sat(int1 + x - fb); int2_n = sat(int2 + int1_n - fb).
  // The feedback is taken from the previous output bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    fb         = sd_out_q ? FS : -FS;
    int1_delta = SUM_W'(x_cur_q) - fb;
    int2_delta = SUM_W'(int1_next) - fb;
  end

  sd_mod_integrator #(
    .ACC_W (CFG.acc_w)
  ) u_int1 (
    .clk        (clk),
    .aresetn    (aresetn),
    .clear_i    (clear),
    .en_i       (ce),
    .delta_i    (int1_delta),
    .acc_next_o (int1_next)
  );

  sd_mod_integrator #(
    .ACC_W (CFG.acc_w)
  ) u_int2 (
    .clk        (clk),
    .aresetn    (aresetn),
    .clear_i    (clear),
    .en_i       (ce),
    .delta_i    (int2_delta),
    .acc_next_o (int2_next)
  );

  // ---------------------------------------------------------------------------
  // Buffer, phase counter, sample load and quantiser.
  // ---------------------------------------------------------------------------
  always_comb begin
    // s_ready is derived from registered state only, so accept never depends
    // combinationally on itself.
    accept         = s_valid && !buf_full_q;
    period_end     = ce && (phase_q == PH_LAST);
    s_data_clamped = IN_W'(sd_clamp(64'(s_data), 64'(CFG.lim)));

    phase_d    = phase_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    x_cur_d    = x_cur_q;
    sd_out_d   = sd_out_q;
    sd_valid_d = 1'b0;
    underrun_d = underrun_q;

    if (clear) begin
      // A sample offered during clear is dropped.
      phase_d    = '0;
      buf_d      = '0;
      buf_full_d = 1'b0;
      x_cur_d    = '0;
      sd_out_d   = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (ce) begin
        phase_d    = period_end ? '0 : phase_q + 1'b1;
        sd_out_d   = !int2_next[ACC_W-1];  // int2_n >= 0
        sd_valid_d = 1'b1;
        if (period_end) begin
          if (buf_full_q) begin
            x_cur_d    = buf_q;
            buf_full_d = 1'b0;
          end else begin
            // x_cur keeps the previous sample for another period.
            underrun_d = 1'b1;
          end
        end
      end
      // Only possible when the buffer was empty before this edge, so it never
      // collides with a load; a sample arriving on the boundary of an empty
      // period is used in the following period.
      if (accept) begin
        buf_d      = s_data_clamped;
        buf_full_d = 1'b1;
      end
    end
  end

  // NOTE: the one-entry buffer is an ordinary register, not a RAM, so it is
  // reset with the rest of the state; only real memory arrays skip reset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      x_cur_q    <= '0;
      sd_out_q   <= 1'b0;
      sd_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      x_cur_q    <= x_cur_d;
      sd_out_q   <= sd_out_d;
      sd_valid_q <= sd_valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign s_ready  = !buf_full_q;
  assign sd_out   = sd_out_q;
  assign sd_valid = sd_valid_q;
  assign frame    = (phase_q == '0);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_sd_modulator.sv
// -----------------------------------------------------------------------------
// tb_sd_modulator
// Self-checking bench for sd_modulator (IN_W=16, OSR=8). A behavioural model
// (integer arithmetic, queue as the input buffer) is stepped alongside the DUT
// every clock; a constant vector table covers the first bits from zero state,
// and hand-written sequences cover density, handshake, ce gating and reset.
// -----------------------------------------------------------------------------
module tb_sd_modulator;

  localparam int IN_W  = 16;
  localparam int OSR   = 8;
  localparam int ACC_W = IN_W + 4;
  localparam int LIM   = 3 * 2 ** (IN_W - 3);

  localparam longint FS   = longint'(1) << (IN_W - 1);
  localparam longint AMAX = (longint'(1) << (ACC_W - 1)) - 1;

  logic            clk     = 1'b0;
  logic            aresetn = 1'b0;
  logic            ce      = 1'b0;
  logic            clear   = 1'b0;
  logic            s_valid = 1'b0;
  logic [IN_W-1:0] s_data  = '0;
  logic            s_ready;
  logic            sd_out;
  logic            sd_valid;
  logic            frame;
  logic            underrun;

  always #5 clk = ~clk;

  sd_modulator #(
    .IN_W  (IN_W),
    .OSR   (OSR),
    .ACC_W (ACC_W),
    .LIM   (LIM)
  ) dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .ce       (ce),
    .clear    (clear),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .sd_out   (sd_out),
    .sd_valid (sd_valid),
    .frame    (frame),
    .underrun (underrun)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int low_cnt = 0;
  int sdv_cnt = 0;
  bit bits[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d..%0d", name, $time, act, lo, hi);
    end
  endtask

  function automatic int ones_in(input int from, input int count);
    int n = 0;
    for (int i = from; i < from + count; i++) begin
      if (i < bits.size() && bits[i]) n++;
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  longint m_int1, m_int2, m_x;
  int     m_phase;
  bit     m_sd, m_sdv, m_under;
  longint m_q[$];

  function automatic longint clampv(input longint v, input longint mag);
    if (v > mag) return mag;
    if (v < -mag) return -mag;
    return v;
  endfunction

  task automatic model_reset();
    m_int1 = 0; m_int2 = 0; m_x = 0; m_phase = 0;
    m_sd = 0; m_sdv = 0; m_under = 0;
    m_q.delete();
  endtask

  task automatic model_edge(input bit ce_v, input bit clr_v, input bit val_v, input longint d);
    longint fb, i1, i2;
    bit     was_empty;
    if (clr_v) begin
      model_reset();
      return;
    end
    was_empty = (m_q.size() == 0);
    m_sdv = 0;
    if (ce_v) begin
      fb     = m_sd ? FS : -FS;
      i1     = clampv(m_int1 + m_x - fb, AMAX);
      i2     = clampv(m_int2 + i1 - fb, AMAX);
      m_int1 = i1;
      m_int2 = i2;
      m_sd   = (i2 >= 0);
      m_sdv  = 1;
      if (m_phase == OSR - 1) begin
        if (m_q.size() > 0) m_x = m_q.pop_front();
        else m_under = 1;
      end
      m_phase = (m_phase + 1) % OSR;
    end
    if (val_v && was_empty) m_q.push_back(clampv(d, LIM));
  endtask

  function automatic logic [4:0] model_outs();
    return {m_q.size() == 0, m_sd, m_sdv, m_phase == 0, m_under};
  endfunction

  // ---------------------------------------------------------------------------
  // One clock: drive inputs, advance model at the edge, compare 1 unit later.
  // ---------------------------------------------------------------------------
  task automatic step(input bit ce_v, input bit clr_v, input bit val_v, input logic [IN_W-1:0] d);
    ce      = ce_v;
    clear   = clr_v;
    s_valid = val_v;
    s_data  = d;
    if (val_v && s_ready && !clr_v) acc_cnt++;
    if (!s_ready) low_cnt++;
    @(posedge clk);
    model_edge(ce_v, clr_v, val_v, longint'($signed(d)));
    #1;
    if (sd_valid) begin
      bits.push_back(sd_out);
      sdv_cnt++;
    end
    check("cycle", {59'd0, s_ready, sd_out, sd_valid, frame, underrun}, {59'd0, model_outs()});
  endtask

  task automatic reset_dut();
    ce = 0; clear = 0; s_valid = 0; s_data = '0;
    aresetn = 0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1;
    model_reset();
    bits.delete();
    acc_cnt = 0; low_cnt = 0; sdv_cnt = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: {ce, clear, s_valid, s_data} -> {s_ready, sd_out, sd_valid, frame, underrun}
  // ---------------------------------------------------------------------------
  typedef struct {
    bit              ce;
    bit              clr;
    bit              val;
    logic [IN_W-1:0] data;
    logic [4:0]      exp;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int ones;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'd0,   5'b10010};  // idle after reset
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'd0,   5'b01100};  // accept 0, bit 1
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b01100};  // bit 1
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b00100};  // bit 0
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'd5,   5'b00000};  // ce=0: hold, full buffer refuses
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b01100};  // bit 1
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b00100};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b00100};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b01100};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b11110};  // load, new period
    tbl[10] = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b10100};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b10100};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b11100};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b11100};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b10100};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b10100};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b11100};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b11111};  // empty boundary -> underrun
    tbl[18] = '{1'b1, 1'b1, 1'b1, 16'd100, 5'b10010};  // clear wins, sample dropped
    tbl[19] = '{1'b1, 1'b0, 1'b0, 16'd0,   5'b11100};  // first bit from zero state

    // Reset and idle: outputs at reset values, no sd_valid with ce=0.
    aresetn = 0;
    #1 check("reset_outs", {s_ready, sd_out, sd_valid, frame, underrun}, 5'b10010);
    reset_dut();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0);
    check("idle_no_valid", sdv_cnt, 0);

    // Vector table.
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].ce, tbl[i].clr, tbl[i].val, tbl[i].data);
      check($sformatf("vec%0d", i), {s_ready, sd_out, sd_valid, frame, underrun}, tbl[i].exp);
    end

    // Zero input.
    reset_dut();
    for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 1'b1, '0);
    check("zero_first_bits", {bits[0], bits[1], bits[2], bits[3]}, 4'b1101);
    for (int w = 0; w < 4; w++) check_range($sformatf("zero_win%0d", w), ones_in(w * 64, 64), 30, 34);
    check("zero_no_underrun", underrun, 0);

    // DC tracking.
    reset_dut();
    for (int i = 0; i < 1024; i++) step(1'b1, 1'b0, 1'b1, 16'h2000);
    check_range("dc_pos_density", ones_in(512, 512), 315, 325);
    reset_dut();
    for (int i = 0; i < 1024; i++) step(1'b1, 1'b0, 1'b1, 16'hE000);
    check_range("dc_neg_density", ones_in(512, 512), 187, 197);

    // Clamp: +32767 behaves as 24576 (0.875 density).
    reset_dut();
    for (int i = 0; i < 2048; i++) step(1'b1, 1'b0, 1'b1, 16'h7FFF);
    check_range("clamp_density", ones_in(1024, 1024), 888, 908);

    // Handshake: one accept per OSR ticks, s_ready low OSR-1 of OSR cycles.
    reset_dut();
    for (int i = 0; i < 80; i++) begin
      if (i == 16) begin
        acc_cnt = 0;
        low_cnt = 0;
      end
      step(1'b1, 1'b0, 1'b1, 16'(i * 37));
    end
    check("hs_accepts", acc_cnt, 8);
    check("hs_ready_low", low_cnt, 56);
    check("hs_no_underrun", underrun, 0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, '0);
    check("underrun_set", underrun, 1);
    step(1'b0, 1'b1, 1'b0, '0);
    check("underrun_cleared", underrun, 0);

    // ce every third cycle.
    reset_dut();
    for (int i = 0; i < 300; i++) step(i % 3 == 0, 1'b0, 1'b1, 16'h2000);
    check("ce_gate_pulses", sdv_cnt, 100);

    // Randomised traffic against the model.
    reset_dut();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
           16'($urandom));

    // Asynchronous reset at phase 5, mid-stream.
    reset_dut();
    for (int k = 0; k < 16 && m_phase != 5; k++) step(1'b1, 1'b0, 1'b1, 16'd1000);
    ce = 0; s_valid = 0;
    #2 aresetn = 0;
    #1 check("async_reset_outs", {s_ready, sd_out, sd_valid, frame, underrun}, 5'b10010);
    @(posedge clk);
    #1 aresetn = 1;
    model_reset();
    bits.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
    check("post_reset_bits", {bits[0], bits[1], bits[2], bits[3]}, 4'b1101);

    ones = ones_in(0, 4);
    check("post_reset_ones", ones, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
